// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/writeback sequencer for the multi-cycle RV32I subset core
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      instr_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             MemWrite_o,
  output logic             AdrSrc_o,
  output logic             IrWrite_o,
  output logic             PcWrite_o,
  output logic             RegWrite_o,
  output logic [1:0]       AluOp_o,
  output logic [1:0]       AluSrcA_o,
  output logic [1:0]       AluSrcB_o,
  output logic [1:0]       ResultSrc_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instret_o
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
  } state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  logic             retire;
  logic [6:0]       op, f7;
  logic [2:0]       f3;
  logic             r_ok, i_ok;
  logic [1:0]       r_op, i_op;
  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];
  // Only add/sub/and/or (and their immediate forms, minus subi) are supported
  assign r_ok = (f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110)) ||
                (f7 == 7'b0100000 && f3 == 3'b000);
  assign i_ok = f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110;
  assign r_op = !r_ok ? 2'b00 : f3 == 3'b111 ? 2'b00 : f3 == 3'b110 ? 2'b01 : f7[5] ? 2'b11 : 2'b10;
  assign i_op = !i_ok ? 2'b00 : f3 == 3'b111 ? 2'b00 : f3 == 3'b110 ? 2'b01 : 2'b10;
  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    MemWrite_o  = 1'b0;
    AdrSrc_o    = 1'b0;
    IrWrite_o   = 1'b0;
    PcWrite_o   = 1'b0;
    RegWrite_o  = 1'b0;
    AluOp_o     = 2'b00;
    AluSrcA_o   = 2'b00;
    AluSrcB_o   = 2'b00;
    ResultSrc_o = 2'b00;
    retire      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        AluSrcB_o   = 2'b10;
        AluOp_o     = 2'b10;
        ResultSrc_o = 2'b10;
        IrWrite_o   = mem_ready_i;
        PcWrite_o   = mem_ready_i;
        state_d     = mem_ready_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        AluSrcA_o = 2'b01;
        AluSrcB_o = 2'b01;
        AluOp_o   = 2'b10;
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = f3 == 3'b000 ? S_BEQ : S_ILLEGAL;
          7'b1101111:             state_d = S_JAL;
          default:                state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        AluSrcA_o = 2'b10;
        AluSrcB_o = 2'b01;
        AluOp_o   = 2'b10;
        state_d   = op == 7'b0000011 ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_o = 1'b1;
        AdrSrc_o  = 1'b1;
        state_d   = mem_ready_i ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc_o = 2'b01;
        RegWrite_o  = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_o  = 1'b1;
        MemWrite_o = 1'b1;
        AdrSrc_o   = 1'b1;
        retire     = mem_ready_i;
        state_d    = mem_ready_i ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        AluSrcA_o = 2'b10;
        AluOp_o   = r_op;
        state_d   = r_ok ? S_ALUWB : S_ILLEGAL;
      end
      S_EXECI: begin
        AluSrcA_o = 2'b10;
        AluSrcB_o = 2'b01;
        AluOp_o   = i_op;
        state_d   = i_ok ? S_ALUWB : S_ILLEGAL;
      end
      S_ALUWB: begin
        RegWrite_o = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        AluSrcA_o = 2'b10;
        AluOp_o   = 2'b11;
        PcWrite_o = zero_i;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        AluSrcA_o = 2'b01;
        AluSrcB_o = 2'b10;
        AluOp_o   = 2'b10;
        PcWrite_o = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase
    instret_d = instret_q + CNT_W'(retire);
    illegal_d = illegal_q | (state_d == S_ILLEGAL);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end
  assign illegal_o = illegal_q;
  assign instret_o = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed then random instruction streams checked against a per-instruction step-plan model
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] instr_i = '0;
  logic        zero_i = 1'b0;
  logic        mem_ready_i = 1'b0;
  logic        mem_req_o, MemWrite_o, AdrSrc_o, IrWrite_o, PcWrite_o, RegWrite_o, illegal_o;
  logic [1:0]  AluOp_o, AluSrcA_o, AluSrcB_o, ResultSrc_o;
  logic [31:0] instret_o;
  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .mem_req_o(mem_req_o), .MemWrite_o(MemWrite_o), .AdrSrc_o(AdrSrc_o), .IrWrite_o(IrWrite_o),
    .PcWrite_o(PcWrite_o), .RegWrite_o(RegWrite_o), .AluOp_o(AluOp_o), .AluSrcA_o(AluSrcA_o),
    .AluSrcB_o(AluSrcB_o), .ResultSrc_o(ResultSrc_o), .illegal_o(illegal_o), .instret_o(instret_o)
  );
  always #5 clk = ~clk;
  typedef enum int {K_F, K_D, K_ADR, K_RD, K_MWB, K_WR, K_EXR, K_EXI, K_WB, K_BEQ, K_JAL, K_ILL} step_t;
  step_t       plan[$];
  step_t       k;
  logic [31:0] cur;
  logic [31:0] m_instret;
  int          dir_i = 0;
  int          ill_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] dir [10] = '{32'h003100B3, 32'h403100B3, 32'h003160B3, 32'h0FF17093, 32'h00012083,
                            32'h00208463, 32'h00208463, 32'h00112023, 32'h0000007F, 32'h00112023};
  logic [31:0] pool [15] = '{32'h003100B3, 32'h403100B3, 32'h003160B3, 32'h003170B3, 32'h00110093,
                             32'h0FF17093, 32'h0FF16093, 32'h00012083, 32'h00112023, 32'h00208463,
                             32'h008000EF, 32'h0000007F, 32'h00209463, 32'h023100B3, 32'h0FF14093};
  function automatic logic [2:0] r_alu(input logic [31:0] i);
    case ({i[31:25], i[14:12]})
      {7'b0000000, 3'b000}: return 3'b110;
      {7'b0100000, 3'b000}: return 3'b111;
      {7'b0000000, 3'b111}: return 3'b100;
      {7'b0000000, 3'b110}: return 3'b101;
      default:              return 3'b000;
    endcase
  endfunction
  function automatic logic [2:0] i_alu(input logic [31:0] i);
    case (i[14:12])
      3'b000:  return 3'b110;
      3'b111:  return 3'b100;
      3'b110:  return 3'b101;
      default: return 3'b000;
    endcase
  endfunction
  task automatic start_next();
    logic [2:0] a;
    cur = dir_i < 10 ? dir[dir_i] : pool[$urandom_range(0, 14)];
    dir_i++;
    plan = '{K_F, K_D};
    case (cur[6:0])
      7'b0000011: begin plan.push_back(K_ADR); plan.push_back(K_RD); plan.push_back(K_MWB); end
      7'b0100011: begin plan.push_back(K_ADR); plan.push_back(K_WR); end
      7'b0110011: begin a = r_alu(cur); plan.push_back(K_EXR); plan.push_back(a[2] ? K_WB : K_ILL); end
      7'b0010011: begin a = i_alu(cur); plan.push_back(K_EXI); plan.push_back(a[2] ? K_WB : K_ILL); end
      7'b1100011: plan.push_back(cur[14:12] == 3'b000 ? K_BEQ : K_ILL);
      7'b1101111: begin plan.push_back(K_JAL); plan.push_back(K_WB); end
      default:    plan.push_back(K_ILL);
    endcase
  endtask
  // Packed as {req, memwrite, adrsrc, irwrite, pcwrite, regwrite, aluop, srca, srcb, resultsrc, illegal}
  function automatic logic [14:0] expect_out(input step_t s, input logic [31:0] i, input logic rdy, input logic z);
    logic req, mw, adr, irw, pcw, rw, ill;
    logic [1:0] aop, sa, sb, rs;
    logic [2:0] a;
    {req, mw, adr, irw, pcw, rw, ill} = '0;
    {aop, sa, sb, rs} = '0;
    case (s)
      K_F:   begin req = 1; sb = 2'b10; aop = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      K_D:   begin sa = 2'b01; sb = 2'b01; aop = 2'b10; end
      K_ADR: begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      K_RD:  begin req = 1; adr = 1; end
      K_MWB: begin rs = 2'b01; rw = 1; end
      K_WR:  begin req = 1; mw = 1; adr = 1; end
      K_EXR: begin a = r_alu(i); sa = 2'b10; aop = a[1:0]; end
      K_EXI: begin a = i_alu(i); sa = 2'b10; sb = 2'b01; aop = a[1:0]; end
      K_WB:  rw = 1;
      K_BEQ: begin sa = 2'b10; aop = 2'b11; pcw = z; end
      K_JAL: begin sa = 2'b01; sb = 2'b10; aop = 2'b10; pcw = 1; end
      default: ill = 1;
    endcase
    return {req, mw, adr, irw, pcw, rw, aop, sa, sb, rs, ill};
  endfunction
  task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, want);
    end
  endtask
  initial begin
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    m_instret = '0;
    start_next();
    for (int c = 0; c < 3000; c++) begin
      #1;
      rst_i = (c == 46) || (c == 51) || (c >= 60 && ($urandom_range(0, 99) == 0 || ill_cnt >= 8));
      mem_ready_i = c < 60 ? !((c >= 19 && c <= 21) || c == 50 || c == 51) : ($urandom_range(0, 3) != 0);
      zero_i = c < 60 ? (c == 26) : 1'($urandom_range(0, 1));
      instr_i = cur;
      #1;
      k = plan[0];
      chk("outputs", c, {17'd0, mem_req_o, MemWrite_o, AdrSrc_o, IrWrite_o, PcWrite_o, RegWrite_o,
                         AluOp_o, AluSrcA_o, AluSrcB_o, ResultSrc_o, illegal_o},
          {17'd0, expect_out(k, cur, mem_ready_i, zero_i)});
      chk("instret", c, instret_o, m_instret);
      if (c == 0)  chk("lit_fetch_irwrite", c, 32'(IrWrite_o), 32'd1);
      if (c == 4)  chk("lit_instret_add", c, instret_o, 32'd1);
      if (c == 6)  chk("lit_sub_aluop", c, 32'(AluOp_o), 32'd3);
      if (c == 10) chk("lit_or_aluop", c, 32'(AluOp_o), 32'd1);
      if (c == 14) chk("lit_andi_aluop", c, 32'(AluOp_o), 32'd0);
      if (c == 16) chk("lit_instret_4", c, instret_o, 32'd4);
      if (c == 20) chk("lit_lw_wait_req_adr", c, 32'({mem_req_o, AdrSrc_o}), 32'd3);
      if (c == 24) chk("lit_lw_8cyc", c, instret_o, 32'd5);
      if (c == 26) chk("lit_beq_taken_pcw", c, 32'(PcWrite_o), 32'd1);
      if (c == 29) chk("lit_beq_nt_pcw", c, 32'(PcWrite_o), 32'd0);
      if (c == 34) chk("lit_instret_8", c, instret_o, 32'd8);
      if (c == 40) chk("lit_illegal_quiet", c, 32'({illegal_o, IrWrite_o, PcWrite_o, RegWrite_o, mem_req_o}), 32'h10);
      if (c == 47) chk("lit_rst_illegal", c, 32'({illegal_o, mem_req_o}), 32'd1);
      if (c == 47) chk("lit_rst_instret", c, instret_o, 32'd0);
      if (c == 52) chk("lit_rst_memwrite", c, 32'({MemWrite_o, mem_req_o}), 32'd1);
      if (c == 52) chk("lit_rst_no_retire", c, instret_o, 32'd0);
      ill_cnt = k == K_ILL ? ill_cnt + 1 : 0;
      if (rst_i) begin
        m_instret = '0;
        start_next();
      end else if (k != K_ILL && (!(k inside {K_F, K_RD, K_WR}) || mem_ready_i)) begin
        if (k inside {K_MWB, K_WR, K_WB, K_BEQ}) m_instret++;
        void'(plan.pop_front());
        if (plan.size() == 0) start_next();
      end
      @(posedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
